uart_cmd_bridge: RTL
====================

Name: uart_cmd_bridge

Overview:
Converts the UART receive byte stream into register-bus transactions for the processor-less SoC, and returns status and read data as a UART transmit byte stream. It sits inside soc between the UART RX/TX byte interface and the peripheral register interconnect (PWM, GPIO, SPI, UART CSRs). The block is the only bus master, so it is how an external host drives the chip's pins.

Parameters:
AddrBytes, 1, number of address bytes per frame, MSB first; bus_addr_o width = 8*AddrBytes
DataBytes, 4, number of data bytes per frame, MSB first; data width = 8*DataBytes
GapCycles, 100000, maximum clk_i cycles allowed between RX bytes of one frame
BusCycles, 64, maximum clk_i cycles from bus_req_o assertion to bus_rvalid_i

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
rx_valid_i  in  1  one-cycle strobe, received byte valid
rx_data_i  in  8  received byte
tx_valid_o  out  1  byte to transmit is valid
tx_data_o  out  8  byte to transmit
tx_ready_i  in  1  UART TX accepts the byte when tx_valid_o && tx_ready_i
bus_req_o  out  1  bus request, held until grant
bus_we_o  out  1  1 = write, 0 = read
bus_addr_o  out  8*AddrBytes  bus address
bus_wdata_o  out  8*DataBytes  write data
bus_gnt_i  in  1  request accepted this cycle
bus_rvalid_i  in  1  response valid (read data or write completion)
bus_rdata_i  in  8*DataBytes  read data
bus_err_i  in  1  error qualifier on bus_rvalid_i
busy_o  out  1  high in any state other than IDLE
drop_o  out  1  one-cycle pulse when an RX byte is discarded

Behaviour:
- Reset: every output is 0. The FSM enters IDLE and the address, data and byte counters clear. Reset takes effect immediately at any point, including mid-frame or mid-bus transaction. No response is sent for an aborted frame.
- Frames: write = 'W' (0x57), addr[AddrBytes], data[DataBytes]. Read = 'R' (0x52), addr[AddrBytes]. Multi-byte fields arrive MSB first.
- Responses: write OK = 'K' (0x4B). Read OK = 'K' followed by data[DataBytes], MSB first. Any error = 'E' (0x45) only.
- FSM states:
  - IDLE: 'W' or 'R' → ADDR. Any other byte → RESP_HDR with 'E'.
  - ADDR: shift in bytes. After the last byte, go to DATA (write) or BUS_REQ (read).
  - DATA: shift in bytes. After the last byte → BUS_REQ.
  - BUS_REQ: bus_req_o=1 with bus_we_o/addr/wdata stable. On bus_gnt_i → BUS_WAIT. bus_req_o drops the cycle after the grant.
  - BUS_WAIT: on bus_rvalid_i, latch bus_rdata_i and the error flag → RESP_HDR.
  - RESP_HDR: tx_valid_o=1. On handshake, go to RESP_DATA for a successful read, otherwise IDLE.
  - RESP_DATA: send DataBytes bytes, then → IDLE.
- bus_rvalid_i may arrive in the same cycle as bus_gnt_i. That is legal and moves BUS_REQ directly to RESP_HDR.
- Gap timer: runs in ADDR and DATA, clears on each accepted byte, and starts at frame begin. Reaching GapCycles returns the FSM to IDLE silently (no response, no bus access).
- Bus timer: runs in BUS_REQ and BUS_WAIT. Reaching BusCycles → RESP_HDR with 'E'. bus_req_o deasserts the same cycle. A late bus_rvalid_i is ignored.
- A read that errors returns 'E' with no data bytes.
- rx_valid_i in BUS_REQ, BUS_WAIT, RESP_HDR or RESP_DATA: the byte is discarded and drop_o pulses in that same cycle. The FSM does not change.
- tx_data_o and tx_valid_o are registered and stay stable while tx_valid_o && !tx_ready_i. tx_ready_i stuck at 0 stalls the FSM indefinitely with no timeout.
- Latency: bus_req_o rises the cycle after the final frame byte. tx_valid_o rises the cycle after bus_rvalid_i.

Decomposition:
- uart_cmd_bridge_pkg holds:
  - command constants CmdWrite=8'h57 and CmdRead=8'h52;
  - response constants RspOk=8'h4B and RspErr=8'h45;
  - the FSM state enum, bridge_state_e.
- One sub-module, uart_cmd_bridge_timer. It is a loadable down-counter with a clear input and a one-cycle expired output, instantiated twice (gap and bus). Counter width is $clog2(limit+1).

Test Plan:
1. Write: RX 57 10 DE AD BE EF → one bus write with addr=0x10, wdata=0xDEADBEEF, we=1. After rvalid with err=0, TX 4B.
2. Read: RX 52 20; bus returns rdata=0x12345678 with err=0 → TX 4B 12 34 56 78. Hold tx_ready_i low for 5 cycles on byte 2 and check that tx_data_o stays 0x34 throughout.
3. Error paths:
   - Unknown command RX 41 → TX 45, no bus activity.
   - Read with bus_err_i=1 → TX 45 only.
   - Grant given but no rvalid for BusCycles → TX 45, and bus_req_o low after the timeout.
4. Gap timeout: RX 57 10 DE, then idle for GapCycles → busy_o falls, no TX, no bus_req_o. A following full read frame then completes correctly.
5. Busy overrun: during BUS_WAIT, RX 52 → drop_o pulses once and the original transaction's response is unchanged.
6. Reset mid-frame: RX 57 10, assert rst_ni low for 1 cycle → all outputs 0 immediately. A following RX 52 10 frame is then parsed as a fresh read.

Source files
------------

// File: rtl/uart_cmd_bridge_pkg.sv
// uart_cmd_bridge_pkg: frame/response byte codes and FSM states shared by the UART command bridge
package uart_cmd_bridge_pkg;
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspOk    = 8'h4B;
  localparam logic [7:0] RspErr   = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_HDR, RESP_DATA} bridge_state_e;

  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_cmd_bridge_timer.sv
// uart_cmd_bridge_timer: loadable down-counter, expired_o pulses during the last enabled count
module uart_cmd_bridge_timer #(
  parameter int Limit = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int W = $clog2(Limit + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (load_i) cnt <= W'(Limit);
    else if (clear_i) cnt <= '0;
    else if (en_i && cnt != '0) cnt <= cnt - W'(1);

  assign expired_o = en_i && cnt == W'(1);
endmodule

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: turns UART command frames into register-bus transactions and streams back status/read data
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter int AddrBytes = 1,
  parameter int DataBytes = 4,
  parameter int GapCycles = 100000,
  parameter int BusCycles = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [8*AddrBytes-1:0] bus_addr_o,
  output logic [8*DataBytes-1:0] bus_wdata_o,
  input  logic                   bus_gnt_i,
  input  logic                   bus_rvalid_i,
  input  logic [8*DataBytes-1:0] bus_rdata_i,
  input  logic                   bus_err_i,
  output logic                   busy_o,
  output logic                   drop_o
);
  localparam int AW = 8 * AddrBytes;
  localparam int DW = 8 * DataBytes;
  localparam int CW = $clog2(max_int(AddrBytes, DataBytes) + 1);

  bridge_state_e state, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d, err_q, err_d;
  logic          tx_valid_d;
  logic [7:0]    tx_data_d;
  logic          hs, gap_load, gap_en, gap_exp, bus_load, bus_en, bus_exp;

  assign hs          = tx_valid_o && tx_ready_i;
  assign gap_en      = state == ADDR || state == DATA;
  assign bus_en      = state == BUS_REQ || state == BUS_WAIT;
  assign gap_load    = rx_valid_i && (gap_en || (state == IDLE && (rx_data_i == CmdWrite || rx_data_i == CmdRead)));
  assign bus_load    = state_d == BUS_REQ && state != BUS_REQ;
  assign busy_o      = state != IDLE;
  assign drop_o      = rx_valid_i && (bus_en || state == RESP_HDR || state == RESP_DATA);
  // request is withdrawn in the very cycle the bus timer runs out
  assign bus_req_o   = state == BUS_REQ && !bus_exp;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

  uart_cmd_bridge_timer #(.Limit(GapCycles)) u_gap (
    .clk_i, .rst_ni, .load_i(gap_load), .en_i(gap_en), .clear_i(!gap_en), .expired_o(gap_exp)
  );

  uart_cmd_bridge_timer #(.Limit(BusCycles)) u_bus (
    .clk_i, .rst_ni, .load_i(bus_load), .en_i(bus_en), .clear_i(!bus_en), .expired_o(bus_exp)
  );

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    err_d      = err_q;
    tx_valid_d = tx_valid_o;
    tx_data_d  = tx_data_o;
    case (state)
      IDLE: if (rx_valid_i) begin
        cnt_d   = '0;
        we_d    = rx_data_i == CmdWrite;
        err_d   = !(rx_data_i == CmdWrite || rx_data_i == CmdRead);
        state_d = err_d ? RESP_HDR : ADDR;
      end
      ADDR: if (rx_valid_i) begin
        addr_d = (addr_q << 8) | AW'(rx_data_i);
        cnt_d  = cnt_q == CW'(AddrBytes - 1) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(AddrBytes - 1)) state_d = we_q ? DATA : BUS_REQ;
      end else if (gap_exp) state_d = IDLE;
      DATA: if (rx_valid_i) begin
        wdata_d = (wdata_q << 8) | DW'(rx_data_i);
        cnt_d   = cnt_q == CW'(DataBytes - 1) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(DataBytes - 1)) state_d = BUS_REQ;
      end else if (gap_exp) state_d = IDLE;
      BUS_REQ: if (bus_exp) begin
        err_d   = 1'b1;
        state_d = RESP_HDR;
      end else if (bus_gnt_i) begin
        state_d = bus_rvalid_i ? RESP_HDR : BUS_WAIT;
        rdata_d = bus_rvalid_i ? bus_rdata_i : rdata_q;
        err_d   = bus_rvalid_i && bus_err_i;
      end
      BUS_WAIT: if (bus_rvalid_i) begin
        rdata_d = bus_rdata_i;
        err_d   = bus_err_i;
        state_d = RESP_HDR;
      end else if (bus_exp) begin
        err_d   = 1'b1;
        state_d = RESP_HDR;
      end
      RESP_HDR: if (hs) begin
        cnt_d      = '0;
        state_d    = err_q || we_q ? IDLE : RESP_DATA;
        tx_valid_d = !(err_q || we_q);
        tx_data_d  = rdata_q[DW-1 -: 8];
        rdata_d    = rdata_q << 8;
      end
      RESP_DATA: if (hs) begin
        state_d    = cnt_q == CW'(DataBytes - 1) ? IDLE : RESP_DATA;
        tx_valid_d = cnt_q != CW'(DataBytes - 1);
        tx_data_d  = rdata_q[DW-1 -: 8];
        rdata_d    = rdata_q << 8;
        cnt_d      = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RESP_HDR && state != RESP_HDR) begin
      tx_valid_d = 1'b1;
      tx_data_d  = err_d ? RspErr : RspOk;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      tx_valid_o <= tx_valid_d;
      tx_data_o  <= tx_data_d;
    end
endmodule
